// File: rtl/ucode_seq_wide.sv
// ucode_seq_wide: multi-lane microcode sequencer sitting between decode (de1)
// and rename (rn0).
//   IDLE     : decode uops pass straight through, up to and including the first
//              lane that traps to microcode.
//   FETCH    : streams up to WIDTH consecutive ROM rows per cycle until EOM.
//              Trap operands in the rows are replaced by the trapped uop's
//              operands.
//   PDG_RSM  : a ucode branch mispredicted; wait for the ROB to resume, then
//              continue from the restore row.
// Ports:
//   clk, reset                 clock, async active-high reset
//   nuke_rb1                   flush; .nuke_useq clears the pending mispredict
//   rename_ready_rn0           rename takes every valid uc0 lane this cycle
//   oldest_robid               age reference for mispredict ordering
//   resume_fetch_rbx           ROB finished mispredict recovery
//   br_mispred_ex0             ucode branch mispredict (robid, ucbr, restore row)
//   valid_de1 / uinstr_de1     decode lanes (in)
//   de1_consume_cnt            decode lanes consumed this cycle
//   valid_uc0 / uinstr_uc0     lanes sent to rename (out)

package uasm;
    localparam int ROM_AW = 7;
    typedef logic [ROM_AW-1:0] t_rom_addr;
    typedef logic [5:0]        t_rob_id;

    typedef enum logic [2:0] {OP_NONE, OP_REG, OP_TRAP_SRC1, OP_TRAP_SRC2, OP_TRAP_DST} t_optype;

    typedef struct packed {
        t_optype    optype;
        logic [5:0] idx;
    } t_opnd;

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  opcode;
        t_opnd       src1;
        t_opnd       src2;
        t_opnd       dst;
        logic        trap_to_ucode;
        t_rom_addr   rom_addr;
        logic        from_ucrom;
        logic        eom;
    } t_uinstr;

    typedef struct packed {
        logic valid;
        logic nuke_useq;
    } t_nuke_pkt;

    typedef struct packed {
        logic      valid;
        t_rob_id   robid;
        logic      ucbr;
        t_rom_addr restore_useq;
    } t_br_mispred_pkt;

    // Ages are measured as distance from the oldest entry, modulo the id space.
    function automatic logic f_robid_a_older_b(t_rob_id a, t_rob_id b, t_rob_id oldest);
        t_rob_id da, db;
        da = a - oldest;
        db = b - oldest;
        return da < db;
    endfunction

    // Microcode ROM contents. Routines end at rows 12, 20 and 63.
    function automatic t_uinstr f_ucrom_row(t_rom_addr r);
        t_uinstr row;
        row        = '0;
        row.opcode = 8'h40 + 8'(r);
        row.src1   = (r[1:0] == 2'd0) ? '{OP_TRAP_SRC1, 6'(r)} : '{OP_REG, 6'(r)};
        row.src2   = (r[2:0] == 3'd5) ? '{OP_TRAP_SRC2, 6'(r)} : '{OP_REG, 6'(r)};
        row.dst    = r[0] ? '{OP_TRAP_DST, 6'(r)} : '{OP_REG, 6'(r + 7'd1)};
        row.eom    = (r == 7'd12) || (r == 7'd20) || (r == 7'd63);
        return row;
    endfunction
endpackage

module ucode_seq_wide import uasm::*; #(
    parameter  int WIDTH    = 2,
    parameter  int ROM_ROWS = 64,
    localparam int CNT_W    = $clog2(WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  t_nuke_pkt              nuke_rb1,
    input  logic                   rename_ready_rn0,
    input  t_rob_id                oldest_robid,
    input  logic                   resume_fetch_rbx,
    input  t_br_mispred_pkt        br_mispred_ex0,
    input  logic [WIDTH-1:0]       valid_de1,
    input  t_uinstr [WIDTH-1:0]    uinstr_de1,
    output logic [CNT_W-1:0]       de1_consume_cnt,
    output logic [WIDTH-1:0]       valid_uc0,
    output t_uinstr [WIDTH-1:0]    uinstr_uc0
);
    typedef enum logic [1:0] {UC_IDLE, UC_FETCH, UC_PDG_RSM} t_state;

    localparam logic [ROM_AW:0] ROM_END = (ROM_AW + 1)'(ROM_ROWS);

    t_state    state_q;
    t_rom_addr useq_pc_q;
    logic      pdg_q;
    t_rob_id   pdg_robid_q;
    logic      pdg_ucbr_q;
    t_uinstr   trap_q;

    logic                 mq;
    int                   trap_idx;
    logic                 trap_hit;
    t_uinstr              trap_uop;
    logic [WIDTH-1:0]     fetch_vld;
    t_uinstr [WIDTH-1:0]  fetch_row;
    logic                 eom_emit;
    logic [CNT_W-1:0]     pop;

    function automatic t_opnd f_sub(t_opnd o, t_uinstr tu);
        case (o.optype)
            OP_TRAP_SRC1: return tu.src1;
            OP_TRAP_SRC2: return tu.src2;
            OP_TRAP_DST:  return tu.dst;
            default:      return o;
        endcase
    endfunction

    // A new mispredict is taken unless an older one is already pending.
    assign mq = br_mispred_ex0.valid &
                (~pdg_q | f_robid_a_older_b(br_mispred_ex0.robid, pdg_robid_q, oldest_robid));

    // First valid trapping lane; descending scan leaves the lowest index.
    always_comb begin
        trap_idx = WIDTH;
        trap_hit = 1'b0;
        trap_uop = uinstr_de1[0];
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (valid_de1[i] && uinstr_de1[i].trap_to_ucode) begin
                trap_idx = i;
                trap_hit = 1'b1;
                trap_uop = uinstr_de1[i];
            end
        end
    end

    // ROM lanes: stop at the first EOM and at the end of the ROM (no wrap).
    always_comb begin
        logic            eom_seen;
        logic [ROM_AW:0] la;
        t_uinstr         row;
        eom_seen  = 1'b0;
        eom_emit  = 1'b0;
        fetch_vld = '0;
        fetch_row = '0;
        for (int i = 0; i < WIDTH; i++) begin
            la                     = {1'b0, useq_pc_q} + (ROM_AW + 1)'(i);
            row                    = f_ucrom_row(la[ROM_AW-1:0]);
            fetch_vld[i]           = (la < ROM_END) && !eom_seen;
            eom_emit               = eom_emit | (fetch_vld[i] & row.eom);
            eom_seen               = eom_seen | row.eom;
            fetch_row[i]           = row;
            fetch_row[i].src1      = f_sub(row.src1, trap_q);
            fetch_row[i].src2      = f_sub(row.src2, trap_q);
            fetch_row[i].dst       = f_sub(row.dst, trap_q);
            fetch_row[i].pc        = trap_q.pc;
            fetch_row[i].from_ucrom = 1'b1;
            fetch_row[i].rom_addr  = la[ROM_AW-1:0];
        end
    end

    always_comb begin
        valid_uc0  = '0;
        uinstr_uc0 = uinstr_de1;
        case (state_q)
            UC_IDLE: begin
                for (int i = 0; i < WIDTH; i++)
                    valid_uc0[i] = valid_de1[i] && (i <= trap_idx);
            end
            UC_FETCH: begin
                valid_uc0  = fetch_vld;
                uinstr_uc0 = fetch_row;
            end
            default: ;
        endcase
        if (mq || reset)
            valid_uc0 = '0;
        pop = '0;
        for (int i = 0; i < WIDTH; i++)
            pop = pop + CNT_W'(valid_uc0[i]);
        de1_consume_cnt = (state_q == UC_IDLE && rename_ready_rn0) ? pop : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= UC_IDLE;
            useq_pc_q   <= '0;
            pdg_q       <= 1'b0;
            pdg_robid_q <= '0;
            pdg_ucbr_q  <= 1'b0;
            trap_q      <= '0;
        end else begin
            // Mispredict beats a same-cycle nuke.
            if (mq) begin
                pdg_q       <= 1'b1;
                pdg_robid_q <= br_mispred_ex0.robid;
                pdg_ucbr_q  <= br_mispred_ex0.ucbr;
            end else if (nuke_rb1.valid && nuke_rb1.nuke_useq) begin
                pdg_q <= 1'b0;
            end

            if (mq) begin
                useq_pc_q <= br_mispred_ex0.restore_useq;
                state_q   <= UC_PDG_RSM;
            end else begin
                case (state_q)
                    UC_IDLE: if (trap_hit && rename_ready_rn0) begin
                        trap_q    <= trap_uop;
                        useq_pc_q <= trap_uop.rom_addr;
                        state_q   <= UC_FETCH;
                    end
                    UC_FETCH: if (rename_ready_rn0) begin
                        useq_pc_q <= useq_pc_q + t_rom_addr'(pop);
                        if (eom_emit)
                            state_q <= UC_IDLE;
                    end
                    UC_PDG_RSM: if (resume_fetch_rbx)
                        state_q <= pdg_ucbr_q ? UC_FETCH : UC_IDLE;
                    default: state_q <= UC_IDLE;
                endcase
            end
        end
    end

`ifdef ASSERT
    always @(posedge clk)
        if (!reset && state_q == UC_FETCH)
            assert ({1'b0, useq_pc_q} < ROM_END);
`endif
endmodule
